// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: word width, reset PC, PC step
// and the fetch FSM state encoding.
package instruction_fetch_unit_pkg;

    localparam int          WORD_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_READY   = 2'd2,
        ST_DELIVER = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: sync reset, parallel load, and increment by a fixed step.
// Priority is reset > load > increment; arithmetic wraps modulo 2^16.
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = RESET_PC,
    parameter logic [WORD_W-1:0] STEP      = PC_STEP
) (
    input  logic              CLK,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [WORD_W-1:0] pc_o
);

    logic [WORD_W-1:0] pc_q;

    // PC update: reset wins, then redirect load, then sequential step
    always_ff @(posedge CLK) begin
        if (rst_i)       pc_q <= RESET_VAL;
        else if (load_i) pc_q <= load_val_i;
        else if (inc_i)  pc_q <= pc_q + STEP;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, captures the
// returned word, and strobes it into the IR once downstream is not stalled.
// Optional feature macro: IFU_ALIGN_CHECK_EN (odd redirect targets park the
// unit and raise a sticky out_Misaligned flag until reset).
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic              CLK,
    input  logic              in_Reset,
    input  logic              in_Stall,
    input  logic              in_PCWrite,
    input  logic [WORD_W-1:0] in_PCTarget,
    input  logic [WORD_W-1:0] in_MemData,
    input  logic              in_MemValid,
    output logic              out_MemReq,
    output logic [WORD_W-1:0] out_MemAddr,
    output logic [WORD_W-1:0] out_Inst,
    output logic              out_IRWrite,
    output logic [WORD_W-1:0] out_PC,
    output logic [WORD_W-1:0] out_PCNext
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic              out_Misaligned
`endif
);

    ifu_state_e        state_q, state_d;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] target;
    logic              redirect;
    logic              capture;
    logic              pc_inc;
    logic              park_set;
    logic              parked;
    logic              mem_req_q, ir_write_q;
    logic [WORD_W-1:0] inst_q, pc_out_q;

    // Redirects are ignored while in RESET; in every other state they win.
    assign redirect = in_PCWrite && (state_q != ST_RESET);
    assign capture  = (state_q == ST_FETCH) && in_MemValid && !redirect;
    assign pc_inc   = (state_q == ST_DELIVER) && !redirect;

`ifdef IFU_ALIGN_CHECK_EN
    logic misaligned_q;

    assign target   = in_PCTarget;
    assign park_set = redirect && in_PCTarget[0];
    assign parked   = misaligned_q;

    // Sticky misalignment flag, only cleared by reset
    always_ff @(posedge CLK) begin
        if (in_Reset)      misaligned_q <= 1'b0;
        else if (park_set) misaligned_q <= 1'b1;
    end

    assign out_Misaligned = misaligned_q;
`else
    // Without the check, odd targets are silently aligned down.
    assign target   = {in_PCTarget[WORD_W-1:1], 1'b0};
    assign park_set = 1'b0;
    assign parked   = 1'b0;
`endif

    pc_register #(
        .RESET_VAL (RESET_PC),
        .STEP      (PC_STEP)
    ) u_pc (
        .CLK        (CLK),
        .rst_i      (in_Reset),
        .load_i     (redirect),
        .load_val_i (target),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // Next-state logic; a redirect overrides the normal sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:   state_d = parked ? ST_RESET : ST_FETCH;
            ST_FETCH:   if (in_MemValid) state_d = ST_READY;
            ST_READY:   if (!in_Stall) state_d = ST_DELIVER;
            ST_DELIVER: state_d = ST_FETCH;
            default:    state_d = ST_RESET;
        endcase
        if (redirect) state_d = park_set ? ST_RESET : ST_FETCH;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (in_Reset) state_q <= ST_RESET;
        else          state_q <= state_d;
    end

    // Registered outputs are decoded from the next state so they line up with it
    always_ff @(posedge CLK) begin
        if (in_Reset) begin
            mem_req_q  <= 1'b0;
            ir_write_q <= 1'b0;
            inst_q     <= '0;
            pc_out_q   <= RESET_PC;
        end else begin
            mem_req_q  <= (state_d == ST_FETCH);
            ir_write_q <= (state_d == ST_DELIVER);
            if (capture) begin
                inst_q   <= in_MemData;
                pc_out_q <= pc;
            end
        end
    end

    assign out_MemReq  = mem_req_q;
    assign out_MemAddr = pc;
    assign out_Inst    = inst_q;
    assign out_IRWrite = ir_write_q;
    assign out_PC      = pc_out_q;
    assign out_PCNext  = pc_out_q + PC_STEP;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Inputs change and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        in_Reset = 1'b1;
    logic        in_Stall = 1'b0;
    logic        in_PCWrite = 1'b0;
    logic [15:0] in_PCTarget = 16'h0000;
    logic [15:0] in_MemData = 16'h0000;
    logic        in_MemValid = 1'b0;
    logic        out_MemReq;
    logic [15:0] out_MemAddr;
    logic [15:0] out_Inst;
    logic        out_IRWrite;
    logic [15:0] out_PC;
    logic [15:0] out_PCNext;
`ifdef IFU_ALIGN_CHECK_EN
    logic        out_Misaligned;
`endif

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit dut (
        .CLK         (CLK),
        .in_Reset    (in_Reset),
        .in_Stall    (in_Stall),
        .in_PCWrite  (in_PCWrite),
        .in_PCTarget (in_PCTarget),
        .in_MemData  (in_MemData),
        .in_MemValid (in_MemValid),
        .out_MemReq  (out_MemReq),
        .out_MemAddr (out_MemAddr),
        .out_Inst    (out_Inst),
        .out_IRWrite (out_IRWrite),
        .out_PC      (out_PC),
        .out_PCNext  (out_PCNext)
`ifdef IFU_ALIGN_CHECK_EN
        ,
        .out_Misaligned (out_Misaligned)
`endif
    );

    always #5 CLK = ~CLK;

    // Reset held 3 cycles, then first request the cycle after release
    task automatic test_reset();
        repeat (3) @(negedge CLK);
        total++;
        if ({out_MemReq, out_IRWrite} !== 2'b00) begin
            bad++; $display("FAIL reset_strobes: got req/irw=%b want 00", {out_MemReq, out_IRWrite});
        end
        total++;
        if (out_Inst !== 16'h0000) begin
            bad++; $display("FAIL reset_inst: got %h want 0000", out_Inst);
        end
        total++;
        if ({out_PC, out_PCNext, out_MemAddr} !== {16'h0000, 16'h0002, 16'h0000}) begin
            bad++; $display("FAIL reset_pc: got pc=%h next=%h addr=%h want 0000/0002/0000", out_PC, out_PCNext, out_MemAddr);
        end
        in_Reset = 1'b0;
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0000}) begin
            bad++; $display("FAIL first_req: got req=%b addr=%h want 1/0000", out_MemReq, out_MemAddr);
        end
    endtask

    // Zero-wait memory: capture, strobe two cycles after request start
    task automatic test_zero_wait();
        in_MemValid = 1'b1; in_MemData = 16'h1234;
        @(negedge CLK);
        in_MemValid = 1'b0;
        total++;
        if ({out_MemReq, out_IRWrite, out_Inst, out_PC} !== {2'b00, 16'h1234, 16'h0000}) begin
            bad++; $display("FAIL zw_ready: got req=%b irw=%b inst=%h pc=%h want 0/0/1234/0000", out_MemReq, out_IRWrite, out_Inst, out_PC);
        end
        @(negedge CLK);
        total++;
        if ({out_IRWrite, out_PCNext} !== {1'b1, 16'h0002}) begin
            bad++; $display("FAIL zw_deliver: got irw=%b pcnext=%h want 1/0002", out_IRWrite, out_PCNext);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_IRWrite, out_MemAddr} !== {2'b10, 16'h0002}) begin
            bad++; $display("FAIL zw_next: got req=%b irw=%b addr=%h want 1/0/0002", out_MemReq, out_IRWrite, out_MemAddr);
        end
    endtask

    // Three memory wait cycles: address held four cycles, one strobe only
    task automatic test_wait_states();
        int strobes = 0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0002}) begin
                bad++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want 1/0002", i, out_MemReq, out_MemAddr);
            end
            if (out_IRWrite) strobes++;
            if (i == 3) begin in_MemValid = 1'b1; in_MemData = 16'hABCD; end
            @(negedge CLK);
        end
        in_MemValid = 1'b0;
        total++;
        if ({out_MemReq, out_Inst} !== {1'b0, 16'hABCD}) begin
            bad++; $display("FAIL wait_ready: got req=%b inst=%h want 0/abcd", out_MemReq, out_Inst);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_IRWrite, out_PC} !== {2'b01, 16'h0002} || strobes != 0) begin
            bad++; $display("FAIL wait_deliver: got req=%b irw=%b pc=%h early=%0d want 0/1/0002/0", out_MemReq, out_IRWrite, out_PC, strobes);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_IRWrite, out_MemAddr} !== {2'b10, 16'h0004}) begin
            bad++; $display("FAIL wait_next: got req=%b irw=%b addr=%h want 1/0/0004", out_MemReq, out_IRWrite, out_MemAddr);
        end
    endtask

    // Stall for 5 READY cycles holds the word; strobe right after release
    task automatic test_stall();
        in_MemValid = 1'b1; in_MemData = 16'h5555; in_Stall = 1'b1;
        @(negedge CLK);
        in_MemValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_MemReq, out_IRWrite, out_Inst} !== {2'b00, 16'h5555}) begin
                bad++; $display("FAIL stall_hold[%0d]: got req=%b irw=%b inst=%h want 0/0/5555", i, out_MemReq, out_IRWrite, out_Inst);
            end
            if (i == 4) in_Stall = 1'b0;
            @(negedge CLK);
        end
        total++;
        if ({out_IRWrite, out_Inst, out_PC} !== {1'b1, 16'h5555, 16'h0004}) begin
            bad++; $display("FAIL stall_release: got irw=%b inst=%h pc=%h want 1/5555/0004", out_IRWrite, out_Inst, out_PC);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0006}) begin
            bad++; $display("FAIL stall_next: got req=%b addr=%h want 1/0006", out_MemReq, out_MemAddr);
        end
    endtask

    // Redirect coincident with MemValid drops the word and refetches at target
    task automatic test_redirect();
        in_MemValid = 1'b1; in_MemData = 16'hDEAD;
        in_PCWrite = 1'b1; in_PCTarget = 16'h0040;
        @(negedge CLK);
        in_MemValid = 1'b0; in_PCWrite = 1'b0;
        total++;
        if ({out_MemReq, out_IRWrite, out_MemAddr} !== {2'b10, 16'h0040}) begin
            bad++; $display("FAIL redir_req: got req=%b irw=%b addr=%h want 1/0/0040", out_MemReq, out_IRWrite, out_MemAddr);
        end
        total++;
        if ({out_Inst, out_PC} !== {16'h5555, 16'h0004}) begin
            bad++; $display("FAIL redir_drop: got inst=%h pc=%h want 5555/0004", out_Inst, out_PC);
        end
        in_MemValid = 1'b1; in_MemData = 16'h0F0F;
        @(negedge CLK);
        in_MemValid = 1'b0;
        total++;
        if ({out_Inst, out_PC} !== {16'h0F0F, 16'h0040}) begin
            bad++; $display("FAIL redir_capture: got inst=%h pc=%h want 0f0f/0040", out_Inst, out_PC);
        end
        @(negedge CLK);
        total++;
        if (out_IRWrite !== 1'b1) begin
            bad++; $display("FAIL redir_deliver: got irw=%b want 1", out_IRWrite);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0042}) begin
            bad++; $display("FAIL redir_next: got req=%b addr=%h want 1/0042", out_MemReq, out_MemAddr);
        end
    endtask

    // Redirect in READY discards the held word; fetch at 0xFFFE wraps to 0
    task automatic test_wrap();
        in_MemValid = 1'b1; in_MemData = 16'h1111; in_Stall = 1'b1;
        @(negedge CLK);
        in_MemValid = 1'b0;
        total++;
        if (out_Inst !== 16'h1111) begin
            bad++; $display("FAIL wrap_held: got inst=%h want 1111", out_Inst);
        end
        in_PCWrite = 1'b1; in_PCTarget = 16'hFFFE;
        @(negedge CLK);
        in_PCWrite = 1'b0; in_Stall = 1'b0;
        total++;
        if ({out_MemReq, out_IRWrite, out_MemAddr} !== {2'b10, 16'hFFFE}) begin
            bad++; $display("FAIL wrap_redir: got req=%b irw=%b addr=%h want 1/0/fffe", out_MemReq, out_IRWrite, out_MemAddr);
        end
        in_MemValid = 1'b1; in_MemData = 16'h7777;
        @(negedge CLK);
        in_MemValid = 1'b0;
        total++;
        if ({out_Inst, out_PC, out_PCNext} !== {16'h7777, 16'hFFFE, 16'h0000}) begin
            bad++; $display("FAIL wrap_capture: got inst=%h pc=%h next=%h want 7777/fffe/0000", out_Inst, out_PC, out_PCNext);
        end
        @(negedge CLK);
        total++;
        if (out_IRWrite !== 1'b1) begin
            bad++; $display("FAIL wrap_deliver: got irw=%b want 1", out_IRWrite);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0000}) begin
            bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/0000", out_MemReq, out_MemAddr);
        end
    endtask

    // Odd redirect target: park with sticky flag, or align down to even
    task automatic test_align();
        in_PCWrite = 1'b1; in_PCTarget = 16'h0041;
        @(negedge CLK);
        in_PCWrite = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({out_Misaligned, out_MemReq} !== 2'b10) begin
                bad++; $display("FAIL align_park[%0d]: got mis/req=%b want 10", i, {out_Misaligned, out_MemReq});
            end
            @(negedge CLK);
        end
        in_Reset = 1'b1;
        @(negedge CLK);
        total++;
        if ({out_Misaligned, out_MemReq} !== 2'b00) begin
            bad++; $display("FAIL align_clear: got mis/req=%b want 00", {out_Misaligned, out_MemReq});
        end
`else
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0040}) begin
            bad++; $display("FAIL align_even: got req=%b addr=%h want 1/0040", out_MemReq, out_MemAddr);
        end
        in_Reset = 1'b1;
        @(negedge CLK);
`endif
        in_Reset = 1'b0;
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0000}) begin
            bad++; $display("FAIL align_restart: got req=%b addr=%h want 1/0000", out_MemReq, out_MemAddr);
        end
    endtask

    // Reset mid-request beats both MemValid and a redirect in the same cycle
    task automatic test_reset_mid();
        in_Reset = 1'b1; in_MemValid = 1'b1; in_MemData = 16'h9999;
        in_PCWrite = 1'b1; in_PCTarget = 16'h0080;
        @(negedge CLK);
        in_Reset = 1'b0; in_MemValid = 1'b0; in_PCWrite = 1'b0;
        total++;
        if ({out_MemReq, out_IRWrite, out_Inst, out_MemAddr} !== {2'b00, 16'h0000, 16'h0000}) begin
            bad++; $display("FAIL midreset: got req=%b irw=%b inst=%h addr=%h want 0/0/0000/0000", out_MemReq, out_IRWrite, out_Inst, out_MemAddr);
        end
        @(negedge CLK);
        total++;
        if ({out_MemReq, out_MemAddr} !== {1'b1, 16'h0000}) begin
            bad++; $display("FAIL midreset_restart: got req=%b addr=%h want 1/0000", out_MemReq, out_MemAddr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect();
        test_wrap();
        test_align();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the 16-bit multicycle processor: holds the program counter, issues one instruction-memory read at a time, and delivers each returned word to the instruction register together with a one-cycle IR write strobe. It sits directly upstream of the instruction register / immediate generator / register file datapath, driving its `in_Inst` and `in_IRWrite` inputs, and accepts PC redirects from the branch/jump logic.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `PC_STEP`, 2, sequential PC increment in bytes.
- `CLK`  input  1  system clock; all state updates on rising edge.
- `in_Reset`  input  1  synchronous, active-high reset.
- `in_Stall`  input  1  downstream busy; hold the fetched instruction, no IR write.
- `in_PCWrite`  input  1  redirect request; wins over all other events.
- `in_PCTarget`  input  16  redirect target address.
- `in_MemData`  input  16  instruction word from memory.
- `in_MemValid`  input  1  `in_MemData` valid; honoured only while `out_MemReq`=1.
- `out_MemReq`  output  1  read request, held until `in_MemValid`.
- `out_MemAddr`  output  16  read address, equals current PC, stable while requesting.
- `out_Inst`  output  16  last captured instruction (to IR `in_Inst`).
- `out_IRWrite`  output  1  one-cycle strobe: write `out_Inst` into the IR.
- `out_PC`  output  16  address of the instruction in `out_Inst`.
- `out_PCNext`  output  16  `out_PC + PC_STEP` (link value for jal).

## Operation
- States: RESET, FETCH, READY, DELIVER.
- RESET: entered for every cycle `in_Reset`=1. PC=`RESET_PC`; `out_MemReq`=0, `out_IRWrite`=0, `out_Inst`=0, `out_PC`=`RESET_PC`. Exits to FETCH on first cycle `in_Reset`=0.
- FETCH: `out_MemReq`=1, `out_MemAddr`=PC. On `in_MemValid`: capture `in_MemData` into `out_Inst`, PC into `out_PC`; go READY.
- READY: `out_MemReq`=0. If `in_Stall`=0 go DELIVER; else stay (instruction held indefinitely).
- DELIVER: `out_IRWrite`=1 for exactly this cycle; PC ← PC + `PC_STEP`; go FETCH.
- Redirect: `in_PCWrite`=1 in any non-reset state → PC ← `in_PCTarget`, next state FETCH; any in-flight request abandoned, `in_MemValid` in the same cycle dropped, pending READY instruction discarded, no IR write that cycle or from the discarded word.
- Reset has priority over redirect; reset mid-request abandons the request.
- PC arithmetic modulo 2^16: 16'hFFFE + 2 → 16'h0000.
- Exactly one outstanding request; `out_MemAddr` never changes while `out_MemReq`=1 except on redirect.

## Timing
- All outputs registered except `out_MemAddr` (= PC register) and `out_PCNext` (combinational from `out_PC`).
- Zero-wait memory (`in_MemValid` in the first FETCH cycle): FETCH→READY→DELIVER, IR strobe 2 cycles after request start; throughput 1 instruction / 3 cycles.
- Each memory wait cycle adds one cycle; each stall cycle in READY adds one cycle.
- `out_Inst`, `out_PC` stable from READY entry through DELIVER and until the next capture.
- First request issued the cycle after `in_Reset` deasserts.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined: adds output `out_Misaligned` (1 bit, reset 0). A redirect to an odd target sets it sticky, PC loads the target, and the unit parks in RESET-like idle (`out_MemReq`=0) until `in_Reset`.
- Not defined: no extra port; `in_PCTarget[0]` forced to 0 on redirect, fetch continues normally.

## Structure
- Shared processor package/header: state encodings, `RESET_PC` default, `PC_STEP`, 16-bit word width constant.
- One sub-module: `pc_register` (16-bit register with sync reset, load, and increment-by-step enables); FSM and capture registers in the top.

## Test plan
- Reset held 3 cycles, released, zero-wait memory returns 16'h1234 at 0x0000 → `out_IRWrite` pulse 2 cycles after request, `out_Inst`=16'h1234, `out_PC`=0x0000, next `out_MemAddr`=0x0002.
- Memory with 3 wait cycles → `out_MemAddr` stable 4 cycles, single IR strobe, no second request before DELIVER.
- `in_Stall`=1 for 5 cycles while READY → no strobe, `out_Inst` held; strobe first cycle after stall drops.
- `in_PCWrite`=1 target 0x0040 coincident with `in_MemValid` → word dropped, no strobe, next request at 0x0040.
- PC at 0xFFFE fetches then increments → next `out_MemAddr`=0x0000.
- Macro defined, redirect to 0x0041 → `out_Misaligned`=1, `out_MemReq`=0 until reset clears it; macro undefined → fetch from 0x0040.
